music_sequencer: RTL and testbench



---
 rtl/music_sequencer_pkg.sv | 34 +++
 rtl/music_sequencer_if.sv | 38 +++
 rtl/music_sequencer_beat_timer.sv | 51 +++++
 rtl/music_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_music_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/music_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// music_sequencer_pkg : shared encodings and defaults for the music sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package music_sequencer_pkg;

  localparam int NOTE_WIDTH_DEF = 5;
  localparam int BEAT_WIDTH_DEF = 3;
  localparam int DATA_WIDTH_DEF = NOTE_WIDTH_DEF + BEAT_WIDTH_DEF;
  localparam int DEPTH_BIT_DEF  = 7;

  // Note code 0 is silence; a beats field of 0 terminates the song.
  localparam int REST_NOTE = 0;
  localparam int END_BEATS = 0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PTR_RST = 3'd1,
    S_FETCH   = 3'd2,
    S_WAIT    = 3'd3,
    S_PLAY    = 3'd4,
    S_GAP     = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/music_sequencer_if.sv
// ----------------------------------------------------------------------------
// music_sequencer_if : read handshake between the sequencer and music memory
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface music_sequencer_if
  import music_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH_BIT  = DEPTH_BIT_DEF
) ();

  logic                  mem_read_en;
  logic                  mem_read_rst;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_ready;
  logic [DEPTH_BIT-1:0]  song_len;

  modport master (
    output mem_read_en,
    output mem_read_rst,
    input  mem_data,
    input  mem_ready,
    input  song_len
  );

  modport slave (
    input  mem_read_en,
    input  mem_read_rst,
    output mem_data,
    output mem_ready,
    output song_len
  );

endinterface

`default_nettype wire

// File: rtl/music_sequencer_beat_timer.sv
// ----------------------------------------------------------------------------
// music_sequencer_beat_timer : tick/beat down-timer shared by note and gap
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module music_sequencer_beat_timer #(
  parameter int TICK_WIDTH = 4,
  parameter int BEAT_WIDTH = 3
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  load,
  input  wire logic                  enable,
  input  wire logic [TICK_WIDTH-1:0] ticks_m1,
  input  wire logic [BEAT_WIDTH-1:0] beats_m1,
  output logic                       expired
);

  logic [TICK_WIDTH-1:0] tick_max;
  logic [TICK_WIDTH-1:0] tick_cnt;
  logic [BEAT_WIDTH-1:0] beat_max;
  logic [BEAT_WIDTH-1:0] beat_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_max <= '0;
      tick_cnt <= '0;
      beat_max <= '0;
      beat_cnt <= '0;
    end else if (load) begin
      tick_max <= ticks_m1;
      beat_max <= beats_m1;
      tick_cnt <= '0;
      beat_cnt <= '0;
    end else if (enable) begin
      if (tick_cnt == tick_max) begin
        tick_cnt <= '0;
        beat_cnt <= beat_cnt + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  // Fires on the last enabled cycle so the owner can leave in the same edge.
  assign expired = enable && (tick_cnt == tick_max) && (beat_cnt == beat_max);

endmodule

`default_nettype wire

// File: rtl/music_sequencer.sv
// ----------------------------------------------------------------------------
// music_sequencer : fetches note words from music memory and times playback
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module music_sequencer
  import music_sequencer_pkg::*;
#(
  parameter int NOTE_WIDTH     = NOTE_WIDTH_DEF,
  parameter int BEAT_WIDTH     = BEAT_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int DEPTH_BIT      = DEPTH_BIT_DEF,
  parameter int TICKS_PER_BEAT = 12500000,
  parameter int GAP_TICKS      = 1250000,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  start,
  input  wire logic                  pause,
  input  wire logic                  stop,
  music_sequencer_if.master          mem,
  output logic [NOTE_WIDTH-1:0]      note_out,
  output logic                       note_valid,
  output logic [DEPTH_BIT-1:0]       note_index,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam int TICK_SPAN  = (TICKS_PER_BEAT > GAP_TICKS) ? TICKS_PER_BEAT : GAP_TICKS;
  localparam int TICK_WIDTH = clog2_min1(TICK_SPAN);
  localparam int WAIT_WIDTH = clog2_min1(TIMEOUT_CYCLES);

  localparam logic [TICK_WIDTH-1:0] PLAY_TICKS_M1 = TICK_WIDTH'(TICKS_PER_BEAT - 1);
  localparam logic [TICK_WIDTH-1:0] GAP_TICKS_M1  = TICK_WIDTH'(GAP_TICKS - 1);
  localparam logic [WAIT_WIDTH-1:0] WAIT_LAST     = WAIT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [NOTE_WIDTH-1:0] REST_CODE     = NOTE_WIDTH'(REST_NOTE);
  localparam logic [BEAT_WIDTH-1:0] END_CODE      = BEAT_WIDTH'(END_BEATS);

  state_t state;
  state_t next_state;

  logic [NOTE_WIDTH-1:0] note_field;
  logic [BEAT_WIDTH-1:0] beats_field;
  logic [WAIT_WIDTH-1:0] wait_cnt;
  logic [DEPTH_BIT-1:0]  index_inc;
  logic                  wait_timeout;
  logic                  timer_load;
  logic                  timer_en;
  logic                  timer_expired;
  logic [TICK_WIDTH-1:0] timer_ticks_m1;
  logic [BEAT_WIDTH-1:0] timer_beats_m1;
  logic                  read_en_q;
  logic                  read_rst_q;

  assign note_field   = mem.mem_data[DATA_WIDTH-1 -: NOTE_WIDTH];
  assign beats_field  = mem.mem_data[BEAT_WIDTH-1:0];
  assign index_inc    = note_index + 1'b1;
  assign wait_timeout = (state == S_WAIT) && !mem.mem_ready && (wait_cnt == WAIT_LAST);
  assign timer_en     = ((state == S_PLAY) || (state == S_GAP)) && !pause;

  assign mem.mem_read_en  = read_en_q;
  assign mem.mem_read_rst = read_rst_q;

  music_sequencer_beat_timer #(
    .TICK_WIDTH (TICK_WIDTH),
    .BEAT_WIDTH (BEAT_WIDTH)
  ) u_beat_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .enable   (timer_en),
    .ticks_m1 (timer_ticks_m1),
    .beats_m1 (timer_beats_m1),
    .expired  (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state     = state;
    timer_load     = 1'b0;
    timer_ticks_m1 = PLAY_TICKS_M1;
    timer_beats_m1 = beats_field - 1'b1;
    case (state)
      S_IDLE: begin
        if (start && !stop) next_state = S_PTR_RST;
      end
      S_PTR_RST: begin
        next_state = (mem.song_len == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        next_state = S_WAIT;
      end
      S_WAIT: begin
        if (mem.mem_ready) begin
          if (beats_field == END_CODE) begin
            next_state = S_DONE;
          end else begin
            next_state = S_PLAY;
            timer_load = 1'b1;
          end
        end else if (wait_timeout) begin
          next_state = S_IDLE;
        end
      end
      S_PLAY: begin
        if (timer_expired) begin
          next_state     = S_GAP;
          timer_load     = 1'b1;
          timer_ticks_m1 = GAP_TICKS_M1;
          timer_beats_m1 = '0;
        end
      end
      S_GAP: begin
        if (timer_expired) next_state = (index_inc == mem.song_len) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
    if (stop && (state != S_IDLE)) next_state = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_en_q  <= 1'b0;
      read_rst_q <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
      wait_cnt   <= '0;
      note_index <= '0;
      note_out   <= '0;
      note_valid <= 1'b0;
    end else begin
      read_en_q  <= (next_state == S_FETCH);
      read_rst_q <= (next_state == S_PTR_RST);
      done       <= (next_state == S_DONE);
      busy       <= (next_state != S_IDLE);
      wait_cnt   <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;

      if ((state == S_IDLE) && (next_state == S_PTR_RST)) begin
        error <= 1'b0;
      end else if (wait_timeout && !stop) begin
        error <= 1'b1;
      end

      if ((next_state == S_IDLE) || (next_state == S_PTR_RST)) begin
        note_index <= '0;
      end else if ((state == S_GAP) && timer_expired) begin
        note_index <= index_inc;
      end

      // note_out survives the gap; only song end or abort clears it.
      if ((next_state == S_IDLE) || (next_state == S_DONE)) begin
        note_out <= '0;
      end else if ((state == S_WAIT) && (next_state == S_PLAY)) begin
        note_out <= note_field;
      end

      if (next_state == S_PLAY) begin
        note_valid <= (state == S_WAIT) ? (note_field != REST_CODE)
                                        : ((note_out != REST_CODE) && !pause);
      end else begin
        note_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_music_sequencer.sv
// ----------------------------------------------------------------------------
// tb_music_sequencer : song table plus corner-case sequences with note scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_music_sequencer;

  localparam int TPB  = 4;
  localparam int GAPT = 2;
  localparam int TOUT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pause;
  logic       stop;
  logic [4:0] note_out;
  logic       note_valid;
  logic [6:0] note_index;
  logic       busy;
  logic       done;
  logic       error;

  music_sequencer_if #(.DATA_WIDTH(8), .DEPTH_BIT(7)) mem_bus ();

  music_sequencer #(
    .TICKS_PER_BEAT (TPB),
    .GAP_TICKS      (GAPT),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .mem        (mem_bus.master),
    .note_out   (note_out),
    .note_valid (note_valid),
    .note_index (note_index),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Memory model: ready pulses two cycles after each read strobe.
  logic [7:0] rom [0:3];
  int         ptr;
  logic       rd_d1;
  logic       mem_never;

  always @(posedge clk) begin
    if (rst) begin
      rd_d1             <= 1'b0;
      mem_bus.mem_ready <= 1'b0;
      mem_bus.mem_data  <= 8'h00;
      ptr               <= 0;
    end else begin
      rd_d1             <= mem_bus.mem_read_en;
      mem_bus.mem_ready <= rd_d1 && !mem_never;
      if (rd_d1) begin
        mem_bus.mem_data <= rom[ptr[1:0]];
        ptr              <= ptr + 1;
      end
      if (mem_bus.mem_read_rst) ptr <= 0;
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [4:0] note;
    logic [7:0] len;
  } run_t;

  run_t       exp_q[$];
  logic       sb_en = 1'b0;
  int         run_len = 0;
  logic [4:0] run_note = '0;
  int         n_rd = 0, n_rr = 0, n_done = 0, n_val = 0;

  always @(negedge clk) begin
    run_t e;
    if (!rst) begin
      if (mem_bus.mem_read_en)  n_rd++;
      if (mem_bus.mem_read_rst) n_rr++;
      if (done)                 n_done++;
      if (note_valid)           n_val++;
    end
    if (sb_en) begin
      if (note_valid) begin
        if (run_len > 0) check("run_note_stable", note_out, run_note);
        run_note = note_out;
        run_len++;
      end else if (run_len > 0) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_run", run_len, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_note", run_note, e.note);
          check("sb_len", run_len, e.len);
        end
        run_len = 0;
      end
    end else begin
      run_len = 0;
    end
  end

  int cyc;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_pulse();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done();
    while (!done && cyc < 300) step();
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic load_song(input logic [31:0] w, input int len);
    for (int i = 0; i < 4; i++) rom[i] = w[8*i +: 8];
    mem_bus.song_len = len[6:0];
  endtask

  typedef struct {
    logic [31:0] words;
    int          len;
    int          exp_cycles;
    int          exp_reads;
    int          exp_valid;
    int          exp_idx;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int rd0, rr0, dn0, vl0;
    logic [7:0] w;

    vecs[0] = '{{8'h00, 8'h00, 8'h49, 8'h2A}, 2, 24, 2, 12, 2};
    vecs[1] = '{{8'h00, 8'h00, 8'h19, 8'h01}, 2, 20, 2, 4, 2};
    vecs[2] = '{{8'h00, 8'h11, 8'h20, 8'h39}, 3, 14, 2, 4, 1};
    vecs[3] = '{{8'h00, 8'h00, 8'h00, 8'h00}, 0, 2, 0, 0, 0};
    vecs[4] = '{{8'h00, 8'h00, 8'h00, 8'hFF}, 1, 35, 1, 28, 1};
    vecs[5] = '{{8'h00, 8'h00, 8'h31, 8'h31}, 2, 20, 2, 8, 2};
    vecs[6] = '{{8'h00, 8'h19, 8'h12, 8'h09}, 3, 33, 3, 16, 3};

    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; mem_never = 1'b0;
    load_song(32'h0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_note_out", note_out, 0);
    check("rst_note_valid", note_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_read_en", mem_bus.mem_read_en, 0);
    check("rst_read_rst", mem_bus.mem_read_rst, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Song table through the scoreboard
    for (int v = 0; v < 7; v++) begin
      load_song(vecs[v].words, vecs[v].len);
      for (int i = 0; i < vecs[v].len; i++) begin
        w = vecs[v].words[8*i +: 8];
        if (w[2:0] == 3'd0) break;
        if (w[7:3] != 5'd0) exp_q.push_back('{note: w[7:3], len: 8'(w[2:0] * TPB)});
      end
      rd0 = n_rd; rr0 = n_rr; dn0 = n_done; vl0 = n_val;
      sb_en = 1'b1;
      start_pulse();
      wait_done();
      check("vec_done_cycle", cyc, vecs[v].exp_cycles);
      check("vec_done_index", note_index, vecs[v].exp_idx);
      repeat (3) step();
      check("vec_busy_after", busy, 0);
      check("vec_done_count", n_done - dn0, 1);
      check("vec_reads", n_rd - rd0, vecs[v].exp_reads);
      check("vec_ptr_rsts", n_rr - rr0, 1);
      check("vec_valid_cycles", n_val - vl0, vecs[v].exp_valid);
      check("vec_sb_leftover", exp_q.size(), 0);
      sb_en = 1'b0;
      exp_q.delete();
    end

    // Handshake and output timing for the two-note song
    load_song({8'h00, 8'h00, 8'h49, 8'h2A}, 2);
    start_pulse();
    check("t_c1_read_rst", mem_bus.mem_read_rst, 1);
    check("t_c1_read_en", mem_bus.mem_read_en, 0);
    check("t_c1_busy", busy, 1);
    step();
    check("t_c2_read_en", mem_bus.mem_read_en, 1);
    check("t_c2_read_rst", mem_bus.mem_read_rst, 0);
    while (cyc < 5) step();
    check("t_c5_valid", note_valid, 1);
    check("t_c5_note", note_out, 5);
    check("t_c5_index", note_index, 0);
    while (cyc < 13) step();
    check("t_gap_valid", note_valid, 0);
    check("t_gap_note", note_out, 5);
    while (cyc < 18) step();
    check("t_c18_note", note_out, 9);
    check("t_c18_index", note_index, 1);
    wait_done();
    check("t_done_cycle", cyc, 24);
    step();
    check("t_busy_fall", busy, 0);
    check("t_done_fall", done, 0);

    // Pause for five cycles in the middle of an 8-cycle note
    load_song({8'h00, 8'h00, 8'h00, 8'h2A}, 1);
    vl0 = n_val;
    start_pulse();
    while (cyc < 7) step();
    pause = 1'b1;
    step(); step();
    check("p_valid_paused", note_valid, 0);
    check("p_note_held", note_out, 5);
    check("p_busy", busy, 1);
    while (cyc < 12) step();
    pause = 1'b0;
    wait_done();
    check("p_done_cycle", cyc, 20);
    repeat (2) step();
    check("p_valid_cycles", n_val - vl0, 8);

    // Memory never answers: timeout, then restart clears error
    mem_never = 1'b1;
    load_song({8'h00, 8'h00, 8'h00, 8'h29}, 1);
    dn0 = n_done;
    start_pulse();
    while (cyc < 10) step();
    check("to_error_early", error, 0);
    check("to_busy_waiting", busy, 1);
    step();
    check("to_error", error, 1);
    check("to_busy", busy, 0);
    check("to_valid", note_valid, 0);
    repeat (3) step();
    check("to_no_done", n_done - dn0, 0);
    mem_never = 1'b0;
    start_pulse();
    check("to_error_cleared", error, 0);
    wait_done();
    check("to_retry_done_cycle", cyc, 11);
    repeat (2) step();

    // stop during PLAY
    load_song({8'h00, 8'h00, 8'h00, 8'h2A}, 1);
    dn0 = n_done;
    start_pulse();
    while (cyc < 7) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_valid", note_valid, 0);
    check("stop_note", note_out, 0);
    repeat (3) step();
    check("stop_no_done", n_done - dn0, 0);

    // stop in PTR_RST suppresses the following read strobe
    start_pulse();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_ptr_read_en", mem_bus.mem_read_en, 0);
    check("stop_ptr_busy", busy, 0);
    repeat (3) step();

    // rst during WAIT
    dn0 = n_done;
    start_pulse();
    while (cyc < 3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstw_busy", busy, 0);
    check("rstw_valid", note_valid, 0);
    check("rstw_read_en", mem_bus.mem_read_en, 0);
    repeat (3) step();
    check("rstw_no_done", n_done - dn0, 0);

    // Empty song with start held through DONE restarts after one IDLE cycle
    load_song(32'h0, 0);
    rd0 = n_rd;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 cyc = 1;
    check("e_c1_read_rst", mem_bus.mem_read_rst, 1);
    step();
    check("e_c2_done", done, 1);
    step();
    check("e_c3_busy", busy, 0);
    check("e_c3_read_rst", mem_bus.mem_read_rst, 0);
    step();
    check("e_c4_read_rst", mem_bus.mem_read_rst, 1);
    check("e_c4_busy", busy, 1);
    start = 1'b0;
    wait_done();
    check("e_restart_done_cycle", cyc, 5);
    repeat (2) step();
    check("e_no_reads", n_rd - rd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
